// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Lets the core's instruction-fetch port and data port share one single-port
//   memory that uses the chip_select/busy handshake. Each core-side port keeps
//   its enable/busy handshake. Requests are granted round-robin, and only one
//   memory transaction is in flight at a time.
//
// Ports
//   clock, reset                   : system clock, synchronous active-high reset
//   inst_enable/inst_address       : fetch request and byte address
//   inst_data/inst_busy            : fetched 32-bit instruction, fetch outstanding
//   data_enable/data_address       : data request and byte address
//   data_write_data/_byte_write_en : store data and byte mask (mask of 0 = load)
//   data_read_data/data_busy       : load result, data access outstanding
//   mem_chip_select/mem_address    : one-cycle memory strobe and address
//   mem_write_data/_byte_write_en  : memory write data and byte mask
//   mem_read_data/mem_busy         : memory read data and busy
//
// Build option
//   MEM_ARB_PERF_COUNTERS_EN : adds the saturating 32-bit outputs
//   inst_grant_count, data_grant_count and contention_count.
//
// inst_data selects a 32-bit half of a 64-bit word, so DATA_SIZE is expected to be 64.
module mem_port_arbiter #(
  parameter int unsigned ADDR_SIZE = 64,
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inst_enable,
  input  logic [ADDR_SIZE-1:0]   inst_address,
  output logic [31:0]            inst_data,
  output logic                   inst_busy,
  input  logic                   data_enable,
  input  logic [ADDR_SIZE-1:0]   data_address,
  input  logic [DATA_SIZE-1:0]   data_write_data,
  input  logic [DATA_SIZE/8-1:0] data_byte_write_enable,
  output logic [DATA_SIZE-1:0]   data_read_data,
  output logic                   data_busy,
  output logic                   mem_chip_select,
  output logic [ADDR_SIZE-1:0]   mem_address,
  output logic [DATA_SIZE-1:0]   mem_write_data,
  output logic [DATA_SIZE/8-1:0] mem_byte_write_enable,
  input  logic [DATA_SIZE-1:0]   mem_read_data,
  input  logic                   mem_busy
`ifdef MEM_ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]            inst_grant_count,
  output logic [31:0]            data_grant_count,
  output logic [31:0]            contention_count
`endif
);

  localparam int unsigned LANES = DATA_SIZE / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_SIZE-1:0] inst_addr_q;
  logic [ADDR_SIZE-1:0] data_addr_q;
  logic [DATA_SIZE-1:0] data_wdata_q;
  logic [LANES-1:0]     data_mask_q;
  // Port of the most recent grant (1 = DATA). It is also the owner of the
  // in-flight transaction, because only one transaction is outstanding.
  logic                 grant_data_q;

  logic grant_c;
  logic pick_data_c;
  logic complete_c;

  // Next-state logic, grant selection and completion detection
  always_comb begin
    state_nxt   = state;
    grant_c     = 1'b0;
    pick_data_c = grant_data_q;
    complete_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        // A busy port in IDLE always has a request still waiting for a grant.
        if ((inst_busy || data_busy) && !mem_busy) begin
          grant_c   = 1'b1;
          state_nxt = ST_ISSUE;
          if (inst_busy && data_busy) begin
            pick_data_c = !grant_data_q;
          end else begin
            pick_data_c = data_busy;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!mem_busy) begin
          complete_c = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, request latches, memory-side outputs and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= ST_IDLE;
      grant_data_q          <= 1'b1;
      inst_busy             <= 1'b0;
      data_busy             <= 1'b0;
      inst_addr_q           <= '0;
      data_addr_q           <= '0;
      data_wdata_q          <= '0;
      data_mask_q           <= '0;
      inst_data             <= '0;
      data_read_data        <= '0;
      mem_chip_select       <= 1'b0;
      mem_address           <= '0;
      mem_write_data        <= '0;
      mem_byte_write_enable <= '0;
    end else begin
      state           <= state_nxt;
      mem_chip_select <= grant_c;

      // Acceptance needs busy=0 and completion needs busy=1, so the two
      // never meet on the same port at the same edge.
      if (inst_enable && !inst_busy) begin
        inst_busy   <= 1'b1;
        inst_addr_q <= inst_address;
      end
      if (data_enable && !data_busy) begin
        data_busy    <= 1'b1;
        data_addr_q  <= data_address;
        data_wdata_q <= data_write_data;
        data_mask_q  <= data_byte_write_enable;
      end

      if (grant_c) begin
        grant_data_q <= pick_data_c;
        if (pick_data_c) begin
          mem_address           <= data_addr_q;
          mem_write_data        <= data_wdata_q;
          mem_byte_write_enable <= data_mask_q;
        end else begin
          mem_address           <= inst_addr_q;
          mem_write_data        <= '0;
          mem_byte_write_enable <= '0;
        end
      end

      if (complete_c) begin
        if (grant_data_q) begin
          data_busy <= 1'b0;
          if (data_mask_q == '0) begin
            data_read_data <= mem_read_data;
          end
        end else begin
          inst_busy <= 1'b0;
          inst_data <= inst_addr_q[2] ? mem_read_data[32 +: 32] : mem_read_data[0 +: 32];
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_COUNTERS_EN
  localparam int unsigned CNT_W = 32;

  // Saturating grant and contention counters
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_grant_count <= '0;
      data_grant_count <= '0;
      contention_count <= '0;
    end else if (grant_c) begin
      if (pick_data_c) begin
        if (data_grant_count != '1) data_grant_count <= data_grant_count + CNT_W'(1);
      end else begin
        if (inst_grant_count != '1) inst_grant_count <= inst_grant_count + CNT_W'(1);
      end
      if (inst_busy && data_busy && (contention_count != '1)) begin
        contention_count <= contention_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule
